if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the ARM-style pipeline. Owns the PC, drives
//   the word-addressed instruction memory and loads the IF/ID pipeline register.
//   Handles hazard freeze, branch redirect/flush and multi-cycle memory latency
//   (wait states), so a slower SRAM-backed instruction memory can replace the
//   combinational one without changes to the stage.
// PARAMETERS
//   ADDR_W      32  PC / memory byte-address width
//   RESET_PC    0   PC value after reset
//   WAIT_CYCLES 0   extra cycles per fetch before data is valid (0..15)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous reset, active low
//   freeze       in   1       hazard stall: hold PC and IF/ID register
//   branch_taken in   1       redirect fetch to branch_addr; flush IF/ID
//   branch_addr  in   ADDR_W  branch target (byte address)
//   imem_addr    out  ADDR_W  address to instruction memory (= PC)
//   imem_rdata   in   32      instruction word from memory
//   pc_out       out  ADDR_W  IF/ID: PC+4 of captured instruction
//   instr_out    out  32      IF/ID: captured instruction
//   valid_out    out  1       IF/ID: instr_out is a real instruction
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, wait_cnt=WAIT_CYCLES, pc_out=0,
//     instr_out=0, valid_out=0. Takes effect immediately, no clock needed,
//     including mid-wait. First fetch starts on the first edge after release.
//   imem_addr = pc, combinational from the PC register.
//   wait_cnt: loaded with WAIT_CYCLES whenever a new PC is loaded. Decrements
//     by 1 per cycle while nonzero, including during freeze. Saturates at 0.
//   Per-edge priority (highest first):
//   1 branch_taken: pc <= {branch_addr[ADDR_W-1:2],2'b00}, wait_cnt reloaded,
//     instr_out<=0, pc_out<=0, valid_out<=0. Overrides freeze. Aborts any
//     pending wait.
//   2 freeze: pc, pc_out, instr_out and valid_out hold.
//   3 wait_cnt!=0 (bubble): pc holds, instr_out<=0, valid_out<=0, pc_out holds.
//   4 wait_cnt==0 (capture): instr_out<=imem_rdata, pc_out<=pc+4,
//     valid_out<=1, pc<=pc+4, wait_cnt<=WAIT_CYCLES.
//   Fetch latency: 1 + WAIT_CYCLES cycles per instruction when there is no
//     stall. WAIT_CYCLES=0 gives one instruction per cycle.
//   Arithmetic: pc+4 is modulo 2^ADDR_W (0x..FC wraps to 0). pc[1:0] is always 0.
//   A freeze released when wait_cnt==0 captures on that same edge. No cycle is
//     lost.
//   When branch_taken and freeze are both high, the branch takes priority.
//     The flushed bubble then holds until freeze drops.
// TESTING
//   T1 WAIT=0, mem[0..2]=A,B,C, release reset -> imem_addr 0,4,8 on successive
//      cycles. After edge 1: instr_out=A, pc_out=4, valid_out=1. Edge 2: B, pc_out=8.
//   T2 freeze=1 for 3 cycles while pc=12 -> imem_addr stays 12, IF/ID outputs
//      hold. Edge after release: capture mem[3], pc_out=16.
//   T3 branch_taken=1, branch_addr=0x43, freeze=1 -> next edge imem_addr=0x40,
//      valid_out=0, instr_out=0.
//   T4 WAIT=2, no stalls -> valid_out pattern 0,0,1 repeating. Captures are
//      mem[0], mem[1] with pc_out=4, 8. imem_addr changes only on capture edges.
//   T5 WAIT=2, branch to 0x20 one cycle into a wait -> the pending fetch is
//      dropped. First valid capture is mem[8], three edges after the branch.
//   T6 rst_n pulsed low mid-wait, between clock edges -> outputs are 0 and
//      imem_addr=RESET_PC immediately. Separately, pc=0xFFFFFFFC capture
//      -> pc_out=0, imem_addr=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction memory
// and loads the IF/ID register, with freeze, branch flush and wait states.
module if_fetch_ctrl #(
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter int unsigned          WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic              valid_out
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_valid;

  logic [ADDR_W-1:0] w_branch_pc;
  logic [ADDR_W-1:0] w_pc_next_seq;
  logic [CNT_W-1:0]  w_wait_dec;
  logic              w_wait_done;
  logic              w_unused_addr_lsb;

  // Word-aligned branch target; the byte offset bits of the target are dropped.
  assign w_branch_pc       = {branch_addr[ADDR_W-1:2], 2'b00};
  assign w_unused_addr_lsb = ^branch_addr[1:0];

  // Sequential PC wraps modulo 2^ADDR_W naturally through the adder width.
  assign w_pc_next_seq = r_pc + PC_STEP;

  // Wait counter saturates at zero.
  assign w_wait_done = (r_wait_cnt == '0);
  assign w_wait_dec  = w_wait_done ? '0 : (r_wait_cnt - CNT_W'(1));

  // PC, wait counter and IF/ID register with branch > freeze > bubble > capture priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_wait_cnt <= WAIT_LOAD;
      r_pc_out   <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= w_branch_pc;
      r_wait_cnt <= WAIT_LOAD;
      r_pc_out   <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
    end else if (freeze) begin
      r_wait_cnt <= w_wait_dec;
    end else if (!w_wait_done) begin
      r_wait_cnt <= w_wait_dec;
      r_instr    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= w_pc_next_seq;
      r_wait_cnt <= WAIT_LOAD;
      r_pc_out   <= w_pc_next_seq;
      r_instr    <= imem_rdata;
      r_valid    <= 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign pc_out    = r_pc_out;
  assign instr_out = r_instr;
  assign valid_out = r_valid;

endmodule
